ultra_ram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one port of the 512x49152 dual-port UltraRAM. Typical requesters are the DRAM DMA and the systolic-array sequencer.
Registers one RAM command per cycle, tracks in-flight reads through a latency pipeline and routes read data back to the issuing requester. Out-of-range addresses are trapped before they reach the RAM and are counted.

---
 rtl/ultra_ram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_ultra_ram_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultra_ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one UltraRAM port.
// Registers one command per cycle, traps out-of-range addresses and steers read data back by tag.
module ultra_ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DEPTH        = 49152,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rsp_valid,
  output logic                  r0_rsp_err,
  output logic [DATA_WIDTH-1:0] r0_rsp_data,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rsp_valid,
  output logic                  r1_rsp_err,
  output logic [DATA_WIDTH-1:0] r1_rsp_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic [15:0]           err_count
);

  typedef enum logic {GNT_R0 = 1'b0, GNT_R1 = 1'b1} grant_e;

  // One extra bit so a DEPTH equal to 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  grant_e                  r_last_grant;
  logic                    r_ram_en;
  logic                    r_ram_we;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic [DATA_WIDTH-1:0]   r_ram_di;
  logic [READ_LATENCY:0]   r_tag_v;
  logic [READ_LATENCY:0]   r_tag_id;
  logic [READ_LATENCY:0]   r_tag_err;
  logic [15:0]             r_err_count;

  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_acc;
  logic                    w_we;
  logic                    w_oor;
  logic                    w_issue;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_rsp_data;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (resetn) begin
      if (r0_valid && r1_valid) begin
        w_gnt0 = (r_last_grant == GNT_R1);
        w_gnt1 = (r_last_grant == GNT_R0);
      end else begin
        w_gnt0 = r0_valid;
        w_gnt1 = r1_valid;
      end
    end
  end

  assign w_acc   = w_gnt0 | w_gnt1;
  assign w_we    = w_gnt1 ? r1_we    : r0_we;
  assign w_addr  = w_gnt1 ? r1_addr  : r0_addr;
  assign w_wdata = w_gnt1 ? r1_wdata : r0_wdata;
  assign w_oor   = ({1'b0, w_addr} >= LP_DEPTH);
  assign w_issue = w_acc & ~w_oor;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last_grant <= GNT_R1;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_di     <= '0;
      r_tag_v      <= '0;
      r_tag_id     <= '0;
      r_tag_err    <= '0;
      r_err_count  <= '0;
    end else begin
      r_ram_en <= w_issue;
      r_ram_we <= w_issue & w_we;
      // Trapped commands never touch the RAM-facing address/data registers.
      if (w_issue) begin
        r_ram_addr <= w_addr;
        r_ram_di   <= w_wdata;
      end
      if (w_acc) begin
        r_last_grant <= w_gnt1 ? GNT_R1 : GNT_R0;
      end
      if (w_acc && w_oor && (r_err_count != '1)) begin
        r_err_count <= r_err_count + 16'd1;
      end
      r_tag_v   <= {r_tag_v[READ_LATENCY-1:0],   w_acc & ~w_we};
      r_tag_id  <= {r_tag_id[READ_LATENCY-1:0],  w_gnt1};
      r_tag_err <= {r_tag_err[READ_LATENCY-1:0], w_oor};
    end
  end

  assign w_rsp_data   = r_tag_err[READ_LATENCY] ? '0 : ram_do;

  assign r0_ready     = w_gnt0;
  assign r1_ready     = w_gnt1;
  assign r0_rsp_valid = r_tag_v[READ_LATENCY] & ~r_tag_id[READ_LATENCY];
  assign r1_rsp_valid = r_tag_v[READ_LATENCY] &  r_tag_id[READ_LATENCY];
  assign r0_rsp_err   = r0_rsp_valid & r_tag_err[READ_LATENCY];
  assign r1_rsp_err   = r1_rsp_valid & r_tag_err[READ_LATENCY];
  assign r0_rsp_data  = w_rsp_data;
  assign r1_rsp_data  = w_rsp_data;

  assign ram_en       = r_ram_en;
  assign ram_we       = r_ram_we;
  assign ram_addr     = r_ram_addr;
  assign ram_di       = r_ram_di;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_ultra_ram_port_arbiter.sv
// Bench for ultra_ram_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model with a behavioural RAM.
`timescale 1ns/1ps
module tb_ultra_ram_port_arbiter;
  localparam int DW = 512;
  localparam int AW = 16;
  localparam int DEPTH = 49152;
  localparam int RL = 1;
  localparam logic [DW-1:0] PAT_A5 = {64{8'hA5}};
  localparam logic [DW-1:0] PAT_3C = {64{8'h3C}};
  localparam logic [DW-1:0] PAT_22 = {64{8'h22}};
  localparam logic [DW-1:0] PAT_33 = {64{8'h33}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          q_valid [2];
  logic          q_we    [2];
  logic [AW-1:0] q_addr  [2];
  logic [DW-1:0] q_wdata [2];
  logic          r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
  logic [DW-1:0] r0_rsp_data, r1_rsp_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do = '0;
  logic [15:0]   err_count;

  ultra_ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(q_valid[0]), .r0_ready(r0_ready), .r0_we(q_we[0]), .r0_addr(q_addr[0]),
    .r0_wdata(q_wdata[0]), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_err(r0_rsp_err), .r0_rsp_data(r0_rsp_data),
    .r1_valid(q_valid[1]), .r1_ready(r1_ready), .r1_we(q_we[1]), .r1_addr(q_addr[1]),
    .r1_wdata(q_wdata[1]), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_err(r1_rsp_err), .r1_rsp_data(r1_rsp_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
    .err_count(err_count)
  );

  // Behavioural single-port RAM, read latency 1.
  logic [DW-1:0] ram_mem [0:DEPTH-1] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_di;
      else        ram_do <= ram_mem[ram_addr];
    end
  end

  // Transaction-level reference model.
  typedef struct { int due; int id; bit err; logic [DW-1:0] data; } rsp_t;
  rsp_t          m_q[$];
  logic [DW-1:0] m_mem [int];
  int            m_last;
  logic [15:0]   m_err;
  bit            exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_di;
  bit            exp_rv [2];
  bit            exp_rerr;
  logic [DW-1:0] exp_rdata;
  int            last_acc;
  int            cyc;
  int            n_checks, n_pass;

  function automatic int exp_grant();
    if (resetn !== 1'b1) return -1;
    if (q_valid[0] && q_valid[1]) return 1 - m_last;
    if (q_valid[0]) return 0;
    if (q_valid[1]) return 1;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    q_valid[i] = v; q_we[i] = we; q_addr[i] = a; q_wdata[i] = d;
  endtask

  task automatic tick();
    int g; int a; rsp_t r;
    g = exp_grant();
    last_acc = g;
    @(posedge clk);
    cyc++;
    if (resetn !== 1'b1) begin
      m_q.delete(); m_last = 1; m_err = '0;
      exp_en = 0; exp_we = 0; exp_addr = '0; exp_di = '0;
    end else begin
      exp_en = 0; exp_we = 0;
      if (g >= 0) begin
        m_last = g;
        a = int'(q_addr[g]);
        if (a >= DEPTH) begin
          if (m_err != 16'hFFFF) m_err++;
        end else begin
          exp_en = 1; exp_we = q_we[g]; exp_addr = q_addr[g]; exp_di = q_wdata[g];
          if (q_we[g]) m_mem[a] = q_wdata[g];
        end
        if (!q_we[g]) begin
          r.due = cyc + RL; r.id = g; r.err = (a >= DEPTH);
          r.data = r.err ? '0 : (m_mem.exists(a) ? m_mem[a] : '0);
          m_q.push_back(r);
        end
      end
    end
    while (m_q.size() > 0 && m_q[0].due < cyc) void'(m_q.pop_front());
    exp_rv[0] = 0; exp_rv[1] = 0; exp_rerr = 0; exp_rdata = '0;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      exp_rv[m_q[0].id] = 1; exp_rerr = m_q[0].err; exp_rdata = m_q[0].data;
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 0;
    set_req(0, 1, 0, 16'd1, '0);
    set_req(1, 1, 0, 16'd2, '0);
    repeat (2) tick();
    n_checks++; if ({r0_ready, r1_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {r0_ready, r1_ready}); else n_pass++;
    n_checks++; if ({ram_en, ram_we} !== 2'b00) $display("FAIL reset_ram_en_we got=%b exp=00", {ram_en, ram_we}); else n_pass++;
    n_checks++; if (ram_addr !== '0) $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); else n_pass++;
    n_checks++; if (ram_di !== '0) $display("FAIL reset_ram_di got=%h exp=0", ram_di); else n_pass++;
    n_checks++; if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err} !== 4'b0000)
      $display("FAIL reset_rsp got=%b exp=0000", {r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err}); else n_pass++;
    n_checks++; if (err_count !== 16'h0) $display("FAIL reset_err_count got=%h exp=0", err_count); else n_pass++;
    q_valid[0] = 0; q_valid[1] = 0;
  endtask

  task automatic test_single();
    resetn = 1;
    set_req(0, 1, 1, 16'd5, PAT_A5); #1;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL single_ready got=%b exp=10", {r0_ready, r1_ready}); else n_pass++;
    tick();
    set_req(0, 1, 0, 16'd5, '0); #1;
    n_checks++; if ({ram_en, ram_we} !== 2'b11) $display("FAIL single_wr_cmd got=%b exp=11", {ram_en, ram_we}); else n_pass++;
    n_checks++; if (ram_addr !== 16'd5) $display("FAIL single_wr_addr got=%0d exp=5", ram_addr); else n_pass++;
    n_checks++; if (ram_di !== PAT_A5) $display("FAIL single_wr_di got=%h exp=%h", ram_di, PAT_A5); else n_pass++;
    tick();
    q_valid[0] = 0; #1;
    n_checks++; if ({ram_en, ram_we} !== 2'b10) $display("FAIL single_rd_cmd got=%b exp=10", {ram_en, ram_we}); else n_pass++;
    n_checks++; if (r0_rsp_valid !== 1'b0) $display("FAIL single_rsp_early got=%b exp=0", r0_rsp_valid); else n_pass++;
    tick();
    n_checks++; if ({r0_rsp_valid, r0_rsp_err, r1_rsp_valid} !== 3'b100)
      $display("FAIL single_rsp got=%b exp=100", {r0_rsp_valid, r0_rsp_err, r1_rsp_valid}); else n_pass++;
    n_checks++; if (r0_rsp_data !== PAT_A5) $display("FAIL single_rsp_data got=%h exp=%h", r0_rsp_data, PAT_A5); else n_pass++;
    tick();
    n_checks++; if (r0_rsp_valid !== 1'b0) $display("FAIL single_rsp_one_cycle got=%b exp=0", r0_rsp_valid); else n_pass++;
  endtask

  task automatic test_contention();
    int acc[2]; int seq_code; int nseen;
    acc[0] = 0; acc[1] = 0; seq_code = 0; nseen = 0;
    resetn = 0; q_valid[0] = 0; q_valid[1] = 0;
    tick();
    resetn = 1;
    set_req(0, 1, 0, 16'd5, '0);
    set_req(1, 1, 0, 16'd5, '0);
    for (int c = 0; c < 7; c++) begin
      #1;
      if (c < 4) begin
        n_checks++; if ({r0_ready, r1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01))
          $display("FAIL cont_grant c=%0d got=%b", c, {r0_ready, r1_ready}); else n_pass++;
      end
      n_checks++; if ((int'(r0_rsp_valid) + int'(r1_rsp_valid)) !== ((c >= 2 && c <= 5) ? 1 : 0))
        $display("FAIL cont_rsp_timing c=%0d got=%b%b", c, r0_rsp_valid, r1_rsp_valid); else n_pass++;
      if (r0_rsp_valid === 1'b1) begin
        nseen++; seq_code = seq_code * 2;
        n_checks++; if (r0_rsp_data !== PAT_A5) $display("FAIL cont_r0_data got=%h exp=%h", r0_rsp_data, PAT_A5); else n_pass++;
      end
      if (r1_rsp_valid === 1'b1) begin
        nseen++; seq_code = seq_code * 2 + 1;
        n_checks++; if (r1_rsp_data !== PAT_A5) $display("FAIL cont_r1_data got=%h exp=%h", r1_rsp_data, PAT_A5); else n_pass++;
      end
      tick();
      if (last_acc >= 0) begin
        acc[last_acc]++;
        if (acc[last_acc] == 2) q_valid[last_acc] = 0;
      end
    end
    n_checks++; if (nseen != 4 || seq_code != 5) $display("FAIL cont_order got n=%0d code=%0d exp n=4 code=5", nseen, seq_code); else n_pass++;
  endtask

  task automatic test_out_of_range();
    set_req(1, 1, 0, 16'd49152, '0); #1;
    n_checks++; if (r1_ready !== 1'b1) $display("FAIL oor_ready got=%b exp=1", r1_ready); else n_pass++;
    tick();
    set_req(1, 1, 1, 16'hFFFF, {16{32'hDEADBEEF}}); #1;
    n_checks++; if ({ram_en, ram_we} !== 2'b00) $display("FAIL oor_rd_trap got=%b exp=00", {ram_en, ram_we}); else n_pass++;
    tick();
    set_req(1, 1, 1, 16'd49151, PAT_3C); #1;
    n_checks++; if ({ram_en, ram_we} !== 2'b00) $display("FAIL oor_wr_trap got=%b exp=00", {ram_en, ram_we}); else n_pass++;
    n_checks++; if ({r1_rsp_valid, r1_rsp_err, r0_rsp_valid} !== 3'b110)
      $display("FAIL oor_rsp got=%b exp=110", {r1_rsp_valid, r1_rsp_err, r0_rsp_valid}); else n_pass++;
    n_checks++; if (r1_rsp_data !== '0) $display("FAIL oor_rsp_data got=%h exp=0", r1_rsp_data); else n_pass++;
    n_checks++; if (err_count !== 16'd2) $display("FAIL oor_err_count got=%0d exp=2", err_count); else n_pass++;
    tick();
    set_req(1, 1, 0, 16'd49151, '0); #1;
    n_checks++; if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 16'd49151)
      $display("FAIL top_wr_cmd got=%b addr=%0d exp=11 addr=49151", {ram_en, ram_we}, ram_addr); else n_pass++;
    tick();
    q_valid[1] = 0; #1;
    n_checks++; if ({ram_en, ram_we} !== 2'b10) $display("FAIL top_rd_cmd got=%b exp=10", {ram_en, ram_we}); else n_pass++;
    tick();
    n_checks++; if ({r1_rsp_valid, r1_rsp_err} !== 2'b10) $display("FAIL top_rsp got=%b exp=10", {r1_rsp_valid, r1_rsp_err}); else n_pass++;
    n_checks++; if (r1_rsp_data !== PAT_3C) $display("FAIL top_rsp_data got=%h exp=%h", r1_rsp_data, PAT_3C); else n_pass++;
    n_checks++; if (err_count !== 16'd2) $display("FAIL top_err_count got=%0d exp=2", err_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    q_valid[0] = 0;
    set_req(1, 1, 1, 16'd20, {64{8'h11}}); #1;
    tick();
    set_req(0, 1, 1, 16'd21, PAT_22);
    set_req(1, 1, 1, 16'd22, PAT_33); #1;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL bp_hold got=%b exp=10", {r0_ready, r1_ready}); else n_pass++;
    tick();
    q_valid[0] = 0; #1;
    n_checks++; if (r1_ready !== 1'b1) $display("FAIL bp_next got=%b exp=1", r1_ready); else n_pass++;
    n_checks++; if (ram_addr !== 16'd21 || ram_di !== PAT_22) $display("FAIL bp_r0_cmd addr=%0d exp=21", ram_addr); else n_pass++;
    tick();
    set_req(0, 1, 0, 16'd21, '0);
    set_req(1, 1, 0, 16'd22, '0); #1;
    n_checks++; if (ram_addr !== 16'd22 || ram_di !== PAT_33 || ram_we !== 1'b1)
      $display("FAIL bp_r1_cmd addr=%0d we=%b exp addr=22 we=1", ram_addr, ram_we); else n_pass++;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL bp_toggle got=%b exp=10", {r0_ready, r1_ready}); else n_pass++;
    tick();
    q_valid[0] = 0; #1;
    tick();
    q_valid[1] = 0;
    n_checks++; if (r0_rsp_valid !== 1'b1 || r0_rsp_data !== PAT_22) $display("FAIL bp_r0_rsp v=%b data=%h", r0_rsp_valid, r0_rsp_data); else n_pass++;
    tick();
    n_checks++; if (r1_rsp_valid !== 1'b1 || r1_rsp_data !== PAT_33) $display("FAIL bp_r1_rsp v=%b data=%h", r1_rsp_valid, r1_rsp_data); else n_pass++;
    tick();
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1, 0, 16'd5, '0);
    q_valid[1] = 0; #1;
    tick();
    q_valid[0] = 0; resetn = 0; #1;
    tick();
    set_req(0, 1, 0, 16'd6, '0);
    set_req(1, 1, 0, 16'd7, '0); #1;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b00) $display("FAIL mid_ready got=%b exp=00", {r0_ready, r1_ready}); else n_pass++;
    n_checks++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) $display("FAIL mid_stale_rsp got=%b exp=00", {r0_rsp_valid, r1_rsp_valid}); else n_pass++;
    n_checks++; if ({ram_en, ram_we} !== 2'b00 || ram_addr !== '0 || ram_di !== '0)
      $display("FAIL mid_ram got en=%b we=%b addr=%h", ram_en, ram_we, ram_addr); else n_pass++;
    n_checks++; if (err_count !== 16'h0) $display("FAIL mid_err_count got=%0d exp=0", err_count); else n_pass++;
    resetn = 1; #1;
    n_checks++; if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL mid_first_tie got=%b exp=10", {r0_ready, r1_ready}); else n_pass++;
    tick();
    q_valid[0] = 0; #1;
    n_checks++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) $display("FAIL mid_no_rsp got=%b exp=00", {r0_rsp_valid, r1_rsp_valid}); else n_pass++;
    tick();
    q_valid[1] = 0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 600; c++) begin
      int g;
      for (int i = 0; i < 2; i++) begin
        if (!q_valid[i] && $urandom_range(0, 99) < 60) begin
          case ($urandom_range(0, 9))
            0: a = 16'd49151;
            1: a = 16'd49152;
            2: a = 16'hFFFF;
            3: a = 16'($urandom_range(0, 65535));
            default: a = 16'($urandom_range(0, 7));
          endcase
          set_req(i, 1, 1'($urandom_range(0, 1)), a, {16{32'($urandom())}});
        end
      end
      #1;
      g = exp_grant();
      n_checks++; if ({r0_ready, r1_ready} !== {g == 0, g == 1}) $display("FAIL rnd_ready cyc=%0d got=%b%b grant=%0d", cyc, r0_ready, r1_ready, g); else n_pass++;
      n_checks++; if ({ram_en, ram_we} !== {exp_en, exp_we}) $display("FAIL rnd_cmd cyc=%0d got=%b%b exp=%b%b", cyc, ram_en, ram_we, exp_en, exp_we); else n_pass++;
      if (exp_en) begin
        n_checks++; if (ram_addr !== exp_addr) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, exp_addr); else n_pass++;
      end
      if (exp_we) begin
        n_checks++; if (ram_di !== exp_di) $display("FAIL rnd_di cyc=%0d got=%h exp=%h", cyc, ram_di, exp_di); else n_pass++;
      end
      n_checks++; if ({r0_rsp_valid, r1_rsp_valid} !== {exp_rv[0], exp_rv[1]})
        $display("FAIL rnd_rsp_valid cyc=%0d got=%b%b exp=%b%b", cyc, r0_rsp_valid, r1_rsp_valid, exp_rv[0], exp_rv[1]); else n_pass++;
      if (exp_rv[0]) begin
        n_checks++; if (r0_rsp_err !== exp_rerr || r0_rsp_data !== exp_rdata)
          $display("FAIL rnd_r0_rsp cyc=%0d err=%b data=%h exp err=%b data=%h", cyc, r0_rsp_err, r0_rsp_data, exp_rerr, exp_rdata); else n_pass++;
      end
      if (exp_rv[1]) begin
        n_checks++; if (r1_rsp_err !== exp_rerr || r1_rsp_data !== exp_rdata)
          $display("FAIL rnd_r1_rsp cyc=%0d err=%b data=%h exp err=%b data=%h", cyc, r1_rsp_err, r1_rsp_data, exp_rerr, exp_rdata); else n_pass++;
      end
      n_checks++; if (err_count !== m_err) $display("FAIL rnd_err_count cyc=%0d got=%0d exp=%0d", cyc, err_count, m_err); else n_pass++;
      tick();
      if (last_acc >= 0) q_valid[last_acc] = 0;
    end
    q_valid[0] = 0; q_valid[1] = 0;
    repeat (3) tick();
  endtask

  task automatic test_saturation();
    resetn = 0; q_valid[0] = 0; q_valid[1] = 0;
    tick();
    resetn = 1;
    set_req(0, 1, 1, 16'hFFFF, '0);
    for (int k = 0; k < 65534; k++) tick();
    n_checks++; if (err_count !== 16'hFFFE) $display("FAIL sat_below got=%h exp=fffe", err_count); else n_pass++;
    tick();
    n_checks++; if (err_count !== 16'hFFFF) $display("FAIL sat_reach got=%h exp=ffff", err_count); else n_pass++;
    repeat (2) tick();
    n_checks++; if (err_count !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", err_count); else n_pass++;
    n_checks++; if (ram_en !== 1'b0) $display("FAIL sat_ram_en got=%b exp=0", ram_en); else n_pass++;
    q_valid[0] = 0;
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; last_acc = -1;
    m_last = 1; m_err = '0;
    exp_en = 0; exp_we = 0; exp_addr = '0; exp_di = '0;
    exp_rv[0] = 0; exp_rv[1] = 0; exp_rerr = 0; exp_rdata = '0;
    for (int i = 0; i < 2; i++) set_req(i, 0, 0, '0, '0);
    resetn = 0;
    test_reset();
    test_single();
    test_contention();
    test_out_of_range();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
